data_island_scheduler: RTL and testbench

Sequences HDMI data island periods and shares each island's packet slots between three packet sources: General Control, audio sample, and InfoFrame/ACP. It sits between the packet sources and the TERC4 serializer/encoder path. On each active edge of HSync it opens at most one island. It decides how many packets go into that island and which source owns each 32-character packet slot. It emits the phase, grant and framing strobes that the data island datapath uses to drive preamble, guard bands and packet characters.

---
 rtl/data_island_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_data_island_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_island_scheduler.sv
// -----------------------------------------------------------------------------
// data_island_scheduler
//
// Purpose:
//   Opens at most one HDMI data island per line. It decides how many packets
//   the island carries and which packet source owns each 32-character slot.
//   It drives the phase, grant and framing strobes that the TERC4 datapath
//   uses to emit the preamble, guard bands and packet characters.
//
// Parameters:
//   ISLAND_DELAY  characters from the HSync active edge to the first preamble
//                 character.
//   MAX_PACKETS   maximum packets per island (1..18).
//
// Ports:
//   pixelClock           in   character clock
//   reset                in   asynchronous active-high reset
//   hSync                in   horizontal sync, active-high
//   vSync                in   vertical sync, active-high (gates General Control)
//   request[2:0]         in   packet pending: [0] GC, [1] audio, [2] InfoFrame/ACP
//   grant[2:0]           out  one-hot owner of the current packet slot
//   dataIslandActive     out  high from the first preamble char to the last
//                             trailing guard band char
//   phase[1:0]           out  0 idle, 1 preamble, 2 guard band, 3 packet
//   packetStart          out  pulse on the first character of each slot
//   isFirstIslandPacket  out  high for the whole first slot of the island
//   packetDone           out  pulse on the 32nd character of each slot
// -----------------------------------------------------------------------------
module data_island_scheduler #(
   parameter int ISLAND_DELAY = 100,
   parameter int MAX_PACKETS  = 2
) (
   input  logic       pixelClock,
   input  logic       reset,
   input  logic       hSync,
   input  logic       vSync,
   input  logic [2:0] request,
   output logic [2:0] grant,
   output logic       dataIslandActive,
   output logic [1:0] phase,
   output logic       packetStart,
   output logic       isFirstIslandPacket,
   output logic       packetDone
);

   // The character counter is 8 bits and saturates, so a delay beyond its
   // range is clamped to the saturation value.
   localparam int          DELAY_CLAMP = (ISLAND_DELAY > 255) ? 255 : ISLAND_DELAY;
   localparam logic [7:0]  DELAY_CNT   = DELAY_CLAMP[7:0];
   localparam logic [4:0]  MAX_CNT     = MAX_PACKETS[4:0];

   localparam logic [7:0]  PREAMBLE_LAST = 8'd7;
   localparam logic [7:0]  GUARD_LAST    = 8'd1;
   localparam logic [7:0]  PACKET_LAST   = 8'd31;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT     = 3'd1,
      S_PREAMBLE = 3'd2,
      S_LEAD_GB  = 3'd3,
      S_PACKET   = 3'd4,
      S_TRAIL_GB = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] char_q, char_d;
   logic [4:0] pkt_q, pkt_d;
   logic [2:0] owner_q, owner_d;
   logic       prefer1_q, prefer1_d;   // 1: audio wins a tie with InfoFrame
   logic       hsync_prev_q;

   logic [2:0] grant_q, grant_d;
   logic       active_q, active_d;
   logic [1:0] phase_q, phase_d;
   logic       start_q, start_d;
   logic       first_q, first_d;
   logic       done_q, done_d;

   logic       hsync_edge;
   logic [2:0] elig_req;
   logic [2:0] slot_req;
   logic [2:0] wait_arb;
   logic [2:0] slot_arb;
   logic [7:0] char_inc;
   logic [4:0] pkt_inc;

   // Fixed priority for GC, round-robin between audio and InfoFrame.
   function automatic logic [2:0] arbitrate(input logic [2:0] req, input logic prefer1);
      logic [2:0] g;
      g = 3'b000;
      if (req[0]) begin
         g = 3'b001;
      end else if (req[1] && req[2]) begin
         g = prefer1 ? 3'b010 : 3'b100;
      end else if (req[1]) begin
         g = 3'b010;
      end else if (req[2]) begin
         g = 3'b100;
      end
      return g;
   endfunction

   assign hsync_edge = hSync && !hsync_prev_q;

   // General Control may only be sent during vertical sync.
   assign elig_req = {request[2], request[1], request[0] & vSync};

   // The owner that is just finishing is not considered for the next slot,
   // even if its request has not dropped yet.
   assign slot_req = elig_req & ~owner_q;

   assign wait_arb = arbitrate(elig_req, prefer1_q);
   assign slot_arb = arbitrate(slot_req, prefer1_q);

   assign char_inc = (char_q == 8'hFF) ? char_q : char_q + 8'd1;
   assign pkt_inc  = (pkt_q == 5'h1F) ? pkt_q : pkt_q + 5'd1;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         char_q       <= 8'd0;
         pkt_q        <= 5'd0;
         owner_q      <= 3'b000;
         prefer1_q    <= 1'b1;
         hsync_prev_q <= 1'b0;
         grant_q      <= 3'b000;
         active_q     <= 1'b0;
         phase_q      <= 2'd0;
         start_q      <= 1'b0;
         first_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         char_q       <= char_d;
         pkt_q        <= pkt_d;
         owner_q      <= owner_d;
         prefer1_q    <= prefer1_d;
         hsync_prev_q <= hSync;
         grant_q      <= grant_d;
         active_q     <= active_d;
         phase_q      <= phase_d;
         start_q      <= start_d;
         first_q      <= first_d;
         done_q       <= done_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      char_d    = char_inc;
      pkt_d     = pkt_q;
      owner_d   = owner_q;
      prefer1_d = prefer1_q;

      case (state_q)
         S_IDLE: begin
            char_d = 8'd0;
            if (hsync_edge) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (char_q >= DELAY_CNT) begin
               char_d = 8'd0;
               pkt_d  = 5'd0;
               if (wait_arb != 3'b000) begin
                  state_d = S_PREAMBLE;
                  owner_d = wait_arb;
                  if (wait_arb[1]) prefer1_d = 1'b0;
                  if (wait_arb[2]) prefer1_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_PREAMBLE: begin
            if (char_q == PREAMBLE_LAST) begin
               state_d = S_LEAD_GB;
               char_d  = 8'd0;
            end
         end

         S_LEAD_GB: begin
            if (char_q == GUARD_LAST) begin
               state_d = S_PACKET;
               char_d  = 8'd0;
               pkt_d   = pkt_inc;
            end
         end

         S_PACKET: begin
            if (char_q == PACKET_LAST) begin
               char_d = 8'd0;
               if ((pkt_q < MAX_CNT) && (slot_arb != 3'b000)) begin
                  // Next slot follows immediately after this one.
                  pkt_d   = pkt_inc;
                  owner_d = slot_arb;
                  if (slot_arb[1]) prefer1_d = 1'b0;
                  if (slot_arb[2]) prefer1_d = 1'b1;
               end else begin
                  state_d = S_TRAIL_GB;
               end
            end
         end

         S_TRAIL_GB: begin
            if (char_q == GUARD_LAST) begin
               state_d = S_IDLE;
               char_d  = 8'd0;
            end
         end

         default: begin
            state_d = S_IDLE;
            char_d  = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registered outputs, derived from the state being entered so they line
   // up with the character the state describes.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_d  = 3'b000;
      active_d = 1'b0;
      phase_d  = 2'd0;
      start_d  = 1'b0;
      first_d  = 1'b0;
      done_d   = 1'b0;

      case (state_d)
         S_PREAMBLE: begin
            active_d = 1'b1;
            phase_d  = 2'd1;
         end
         S_LEAD_GB, S_TRAIL_GB: begin
            active_d = 1'b1;
            phase_d  = 2'd2;
         end
         S_PACKET: begin
            active_d = 1'b1;
            phase_d  = 2'd3;
            grant_d  = owner_d;
            start_d  = (char_d == 8'd0);
            done_d   = (char_d == PACKET_LAST);
            first_d  = (pkt_d == 5'd1);
         end
         default: begin
            active_d = 1'b0;
         end
      endcase
   end

   assign grant               = grant_q;
   assign dataIslandActive    = active_q;
   assign phase               = phase_q;
   assign packetStart         = start_q;
   assign isFirstIslandPacket = first_q;
   assign packetDone          = done_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// -----------------------------------------------------------------------------
// tb_data_island_scheduler
//
// Table of per-line scenarios (requests, vSync, optional second HSync pulse)
// with hand-computed island shapes and slot owners, plus hand-written
// sequences for an idle line train and a reset in the middle of a packet.
// Packet sources drop their request on packetDone while they are granted.
// -----------------------------------------------------------------------------
module tb_data_island_scheduler;

   localparam int ISLAND_DELAY = 100;
   localparam int MAX_PACKETS  = 2;
   localparam int LINE_CYCLES  = 400;

   logic       pixelClock;
   logic       reset;
   logic       hSync;
   logic       vSync;
   logic [2:0] request;
   logic [2:0] grant;
   logic       dataIslandActive;
   logic [1:0] phase;
   logic       packetStart;
   logic       isFirstIslandPacket;
   logic       packetDone;

   int total;
   int bad;

   data_island_scheduler #(
      .ISLAND_DELAY (ISLAND_DELAY),
      .MAX_PACKETS  (MAX_PACKETS)
   ) dut (
      .pixelClock          (pixelClock),
      .reset               (reset),
      .hSync               (hSync),
      .vSync               (vSync),
      .request             (request),
      .grant               (grant),
      .dataIslandActive    (dataIslandActive),
      .phase               (phase),
      .packetStart         (packetStart),
      .isFirstIslandPacket (isFirstIslandPacket),
      .packetDone          (packetDone)
   );

   initial pixelClock = 1'b0;
   always #5 pixelClock = ~pixelClock;

   typedef struct {
      logic [2:0] req;
      logic       vs;
      int         hs2;        // extra HSync pulse at this cycle, -1 for none
      int         slots;
      logic [2:0] g0;
      logic [2:0] g1;
      int         exp_first;  // cycles from E to first preamble char, -1 none
      int         exp_len;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [8:0] out_bus();
      return {grant, dataIslandActive, phase, packetStart, isFirstIslandPacket, packetDone};
   endfunction

   // Run one line: HSync edge at E, then watch LINE_CYCLES characters and
   // compare every cycle with the island shape expected from the vector.
   task automatic run_line(input int id, input vec_t v);
      int         first, len, ph_err, gr_err, st_err, k, slot, pos, bad_n;
      logic [1:0] exp_ph;
      logic [2:0] exp_gr;
      logic       exp_ps, exp_pd, exp_if, exp_act;
      first = -1; len = 0; ph_err = 0; gr_err = 0; st_err = 0; bad_n = -1;

      @(negedge pixelClock);
      request = v.req;
      vSync   = v.vs;
      hSync   = 1'b1;
      @(posedge pixelClock);   // edge E
      for (int n = 0; n < LINE_CYCLES; n++) begin
         @(negedge pixelClock);
         if (n == 3) hSync = 1'b0;
         if (v.hs2 >= 0 && n == v.hs2)     hSync = 1'b1;
         if (v.hs2 >= 0 && n == v.hs2 + 3) hSync = 1'b0;

         if (dataIslandActive === 1'b1) begin
            if (first < 0) first = n;
            len++;
         end

         exp_ph = 2'd0; exp_gr = 3'b000; exp_ps = 1'b0; exp_pd = 1'b0; exp_if = 1'b0;
         if (v.slots > 0) begin
            k = n - (ISLAND_DELAY + 1);
            if (k >= 0 && k < 8) begin
               exp_ph = 2'd1;
            end else if (k >= 8 && k < 10) begin
               exp_ph = 2'd2;
            end else if (k >= 10 && k < 10 + 32 * v.slots) begin
               exp_ph = 2'd3;
               slot   = (k - 10) / 32;
               pos    = (k - 10) % 32;
               exp_gr = (slot == 0) ? v.g0 : v.g1;
               exp_ps = (pos == 0);
               exp_pd = (pos == 31);
               exp_if = (slot == 0);
            end else if (k >= 10 + 32 * v.slots && k < 12 + 32 * v.slots) begin
               exp_ph = 2'd2;
            end
         end
         exp_act = (exp_ph != 2'd0);

         if (phase !== exp_ph || dataIslandActive !== exp_act) begin
            ph_err++;
            if (bad_n < 0) bad_n = n;
         end
         if (grant !== exp_gr) begin
            gr_err++;
            if (bad_n < 0) bad_n = n;
         end
         if (packetStart !== exp_ps || packetDone !== exp_pd || isFirstIslandPacket !== exp_if) begin
            st_err++;
            if (bad_n < 0) bad_n = n;
         end

         // A granted source withdraws its request once its packet is done.
         if (packetDone === 1'b1) request = request & ~grant;
      end

      $display("line %0d: req=%b vs=%b first=%0d len=%0d phase_err=%0d grant_err=%0d strobe_err=%0d first_bad_cycle=%0d",
               id, v.req, v.vs, first, len, ph_err, gr_err, st_err, bad_n);
      check($sformatf("line%0d_first_preamble", id), first, v.exp_first);
      check($sformatf("line%0d_island_len", id), len, v.exp_len);
      check($sformatf("line%0d_phase_errs", id), ph_err, 0);
      check($sformatf("line%0d_grant_errs", id), gr_err, 0);
      check($sformatf("line%0d_strobe_errs", id), st_err, 0);
   endtask

   initial begin
      int   idle_err;
      vec_t pv;
      total = 0;
      bad   = 0;

      //                 req     vs    hs2  slots g0      g1      first len
      vecs[0] = '{3'b111, 1'b1,  -1, 2, 3'b001, 3'b010, 101, 76};  // GC then audio
      vecs[1] = '{3'b110, 1'b0,  -1, 2, 3'b100, 3'b010, 101, 76};  // round-robin to InfoFrame
      vecs[2] = '{3'b010, 1'b0,  -1, 1, 3'b010, 3'b000, 101, 44};  // single audio
      vecs[3] = '{3'b001, 1'b0,  -1, 0, 3'b000, 3'b000,  -1,  0};  // GC masked, no island
      vecs[4] = '{3'b100, 1'b1,  -1, 1, 3'b100, 3'b000, 101, 44};  // single InfoFrame
      vecs[5] = '{3'b110, 1'b0, 130, 2, 3'b010, 3'b100, 101, 76};  // 2nd HSync in PACKET ignored
      vecs[6] = '{3'b101, 1'b1,  -1, 2, 3'b001, 3'b100, 101, 76};  // GC then InfoFrame
      vecs[7] = '{3'b000, 1'b1,  -1, 0, 3'b000, 3'b000,  -1,  0};  // nothing pending

      reset   = 1'b1;
      hSync   = 1'b0;
      vSync   = 1'b0;
      request = 3'b000;
      repeat (3) @(negedge pixelClock);
      check("reset_outputs", out_bus(), 0);
      reset = 1'b0;
      repeat (2) @(negedge pixelClock);
      check("post_reset_idle_outputs", out_bus(), 0);

      for (int i = 0; i < 8; i++) begin
         run_line(i, vecs[i]);
      end

      // Idle line train: HSync edges with nothing pending never open an island.
      idle_err = 0;
      request  = 3'b000;
      vSync    = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(negedge pixelClock);
         hSync = ((n % 120) < 10);
         if (out_bus() !== 9'd0) idle_err++;
      end
      hSync = 1'b0;
      $display("idle train: nonzero_output_cycles=%0d", idle_err);
      check("idle_train_outputs", idle_err, 0);

      // Reset in the middle of a packet blanks the outputs at once.
      @(negedge pixelClock);
      request = 3'b010;
      vSync   = 1'b0;
      hSync   = 1'b1;
      @(posedge pixelClock);
      for (int n = 0; n < 120; n++) begin
         @(negedge pixelClock);
         if (n == 3) hSync = 1'b0;
      end
      check("pre_reset_phase_packet", phase, 3);
      check("pre_reset_grant_audio", grant, 3'b010);
      #1 reset = 1'b1;
      #1;
      $display("mid-packet reset: outputs=%b", out_bus());
      check("async_reset_outputs", out_bus(), 0);
      repeat (3) @(negedge pixelClock);
      check("held_reset_outputs", out_bus(), 0);
      reset   = 1'b0;
      request = 3'b000;
      repeat (2) @(negedge pixelClock);
      check("after_release_outputs", out_bus(), 0);

      // The audio grant before reset moved the pointer towards InfoFrame;
      // reset must bring it back to favour audio.
      pv = '{3'b110, 1'b0, -1, 2, 3'b010, 3'b100, 101, 76};
      run_line(8, pv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
